// File: rtl/quad_decoder.sv
//------------------------------------------------------------------------------
// Module   : quad_decoder
// Purpose  : Filtered quadrature decoder with x1/x2/x4 gating, signed position
//            accumulator (wrap or saturate) and debounced push-switch events.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module quad_decoder #(
  parameter int CNT_W       = 16,
  parameter int FILT_CYC    = 4,
  parameter int SW_FILT_CYC = 1000,
  parameter int LONG_CYC    = 25000000,
  parameter int SAT         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ina,
  input  logic             inb,
  input  logic             sw,
  input  logic [1:0]       mode,
  input  logic             pos_clr,
  output logic             sw_out,
  output logic             sw_press,
  output logic             sw_long,
  output logic             cnt,
  output logic             dir,
  output logic [CNT_W-1:0] pos,
  output logic             err
);

  localparam int c_FW  = $clog2(FILT_CYC + 1);
  localparam int c_SFW = $clog2(SW_FILT_CYC + 1);
  localparam int c_HW  = $clog2(LONG_CYC + 1);

  localparam logic [c_FW-1:0]  c_FILT_LAST    = c_FW'(FILT_CYC - 1);
  localparam logic [c_SFW-1:0] c_SW_FILT_LAST = c_SFW'(SW_FILT_CYC - 1);
  localparam logic [c_HW-1:0]  c_LONG         = c_HW'(LONG_CYC);
  localparam logic [c_HW-1:0]  c_LONG_LAST    = c_HW'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] c_POS_MAX      = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] c_POS_MIN      = {1'b1, {(CNT_W-1){1'b0}}};

  // Phase vectors are ordered {a, b}.
  logic [1:0]       r_ab_s1;
  logic [1:0]       r_ab_s2;
  logic [1:0]       w_ab;
  logic [1:0]       r_ab_prev;
  logic [1:0]       w_chg;
  logic             w_illegal;
  logic             w_legal;
  logic             w_up;
  logic             w_gate;
  logic             w_step;
  logic             r_cnt;
  logic             r_dir;
  logic             r_err;
  logic [CNT_W-1:0] r_pos;

  logic             r_sw_s1;
  logic             r_sw_s2;
  logic [c_SFW-1:0] r_sw_fcnt;
  logic             r_sw;
  logic             r_sw_prev;
  logic [c_HW-1:0]  r_hold;
  logic             r_press;
  logic             r_long;

  always_ff @(posedge clk) begin
    r_ab_s1 <= {ina, inb};
    r_ab_s2 <= r_ab_s1;
    r_sw_s1 <= sw;
    r_sw_s2 <= r_sw_s1;
  end

  // During reset the accepted level tracks the synchroniser, so release at rest is silent.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ab_filt
    logic            r_acc;
    logic [c_FW-1:0] r_fcnt;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_acc  <= r_ab_s2[gi];
        r_fcnt <= '0;
      end else if (r_ab_s2[gi] != r_acc) begin
        if (r_fcnt == c_FILT_LAST) begin
          r_acc  <= r_ab_s2[gi];
          r_fcnt <= '0;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end else begin
        r_fcnt <= '0;
      end
    end

    assign w_ab[gi] = r_acc;
  end

  assign w_chg     = w_ab ^ r_ab_prev;
  assign w_illegal = &w_chg;
  assign w_legal   = ^w_chg;
  // Up successor of {a,b} is {~b, a}: 00->10->11->01->00.
  assign w_up      = (w_ab == {~r_ab_prev[0], r_ab_prev[1]});

  always_comb begin
    w_gate = 1'b1;
    case (mode)
      2'd0:    w_gate = (w_ab == 2'b00);
      2'd1:    w_gate = (w_ab == 2'b00) || (w_ab == 2'b11);
      default: w_gate = 1'b1;
    endcase
  end

  assign w_step = w_legal & w_gate;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ab_prev <= r_ab_s2;
      r_cnt     <= 1'b0;
      r_dir     <= 1'b0;
      r_err     <= 1'b0;
      r_pos     <= '0;
    end else begin
      r_ab_prev <= w_ab;
      r_cnt     <= w_step;
      r_err     <= w_illegal;
      if (w_step) begin
        r_dir <= w_up;
      end
      if (pos_clr) begin
        r_pos <= '0;
      end else if (w_step) begin
        if (w_up) begin
          if (!((SAT != 0) && (r_pos == c_POS_MAX))) begin
            r_pos <= r_pos + 1'b1;
          end
        end else begin
          if (!((SAT != 0) && (r_pos == c_POS_MIN))) begin
            r_pos <= r_pos - 1'b1;
          end
        end
      end
    end
  end

  // Hold counter parks at LONG_CYC so the long event fires once per hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sw      <= r_sw_s2;
      r_sw_prev <= r_sw_s2;
      r_sw_fcnt <= '0;
      r_hold    <= '0;
      r_press   <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      if (r_sw_s2 != r_sw) begin
        if (r_sw_fcnt == c_SW_FILT_LAST) begin
          r_sw      <= r_sw_s2;
          r_sw_fcnt <= '0;
        end else begin
          r_sw_fcnt <= r_sw_fcnt + 1'b1;
        end
      end else begin
        r_sw_fcnt <= '0;
      end
      r_sw_prev <= r_sw;
      r_press   <= r_sw & ~r_sw_prev;
      if (r_sw) begin
        if (r_hold != c_LONG) begin
          r_hold <= r_hold + 1'b1;
        end
        r_long <= (r_hold == c_LONG_LAST);
      end else begin
        r_hold <= '0;
        r_long <= 1'b0;
      end
    end
  end

  assign cnt      = r_cnt;
  assign dir      = r_dir;
  assign err      = r_err;
  assign pos      = r_pos;
  assign sw_out   = r_sw;
  assign sw_press = r_press;
  assign sw_long  = r_long;

endmodule

`default_nettype wire

// File: tb/tb_quad_decoder.sv
//------------------------------------------------------------------------------
// Module   : tb_quad_decoder
// Purpose  : Directed self-checking bench; a saturating and a wrapping 4-bit
//            instance share the same pins.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ina, inb, sw, pos_clr;
  logic [1:0] mode;

  logic       sw_out0, sw_press0, sw_long0, cnt0, dir0, err0;
  logic [3:0] pos0;
  logic       sw_out1, sw_press1, sw_long1, cnt1, dir1, err1;
  logic [3:0] pos1;

  int n_chk = 0;
  int n_fail = 0;
  int n_cnt0 = 0, n_cnt1 = 0, n_err0 = 0, n_press = 0, n_long = 0;
  int cyc = 0, t_rise = 0, t_long = 0;
  int base0, base1, ebase;
  logic sw_q = 1'b0;

  localparam logic [1:0] UP [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
  localparam logic [1:0] DN [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quad_decoder #(.CNT_W(4), .FILT_CYC(4), .SW_FILT_CYC(8), .LONG_CYC(50), .SAT(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .sw(sw), .mode(mode),
    .pos_clr(pos_clr), .sw_out(sw_out0), .sw_press(sw_press0), .sw_long(sw_long0),
    .cnt(cnt0), .dir(dir0), .pos(pos0), .err(err0)
  );

  quad_decoder #(.CNT_W(4), .FILT_CYC(4), .SW_FILT_CYC(8), .LONG_CYC(50), .SAT(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ina(ina), .inb(inb), .sw(sw), .mode(mode),
    .pos_clr(pos_clr), .sw_out(sw_out1), .sw_press(sw_press1), .sw_long(sw_long1),
    .cnt(cnt1), .dir(dir1), .pos(pos1), .err(err1)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt0)      n_cnt0++;
      if (cnt1)      n_cnt1++;
      if (err0)      n_err0++;
      if (sw_press0) n_press++;
      if (sw_long0) begin
        n_long++;
        t_long = cyc;
      end
      if (sw_out0 && !sw_q) t_rise = cyc;
    end
    sw_q = sw_out0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic phase(input logic [1:0] ab);
    @(negedge clk);
    ina = ab[1];
    inb = ab[0];
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clear_pos();
    @(negedge clk) pos_clr = 1'b1;
    @(negedge clk) pos_clr = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; ina = 1'b1; inb = 1'b1; sw = 1'b0; mode = 2'd2; pos_clr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_cnt", cnt0, 0);
    check("rst_dir", dir0, 0);
    check("rst_pos", pos0, 0);
    check("rst_err", err0, 0);
    check("rst_press_long", {sw_press0, sw_long0}, 0);
    check("rst_sw_out", sw_out0, 0);

    @(negedge clk) rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rel_no_cnt", n_cnt0 + n_cnt1, 0);
    check("rel_no_err", n_err0, 0);
    check("rel_pos", pos0, 0);

    // 11 -> 10 -> 00 is two down steps
    phase(2'b10);
    phase(2'b00);
    check("init_down_pos", pos0, 4'hE);
    check("init_down_dir", dir0, 0);
    clear_pos();
    check("clr_pos_sat", pos0, 0);
    check("clr_pos_wrap", pos1, 0);

    // x4 up cycle, first step timed from the pin edge
    base0 = n_cnt0;
    @(negedge clk) ina = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("lat_before_6", cnt0, 0);
    @(posedge clk);
    #1;
    check("lat_at_6", cnt0, 1);
    check("lat_dir", dir0, 1);
    @(posedge clk);
    #1;
    check("pulse_width", cnt0, 0);
    repeat (3) @(posedge clk);
    for (int i = 1; i < 4; i++) phase(UP[i]);
    check("x4_up_cnt", n_cnt0 - base0, 4);
    check("x4_up_pos", pos0, 4);
    check("x4_up_dir", dir0, 1);
    for (int i = 0; i < 4; i++) phase(DN[i]);
    check("x4_dn_pos", pos0, 0);
    check("x4_dn_dir", dir0, 0);

    mode = 2'd0;
    base0 = n_cnt0;
    for (int i = 0; i < 8; i++) phase(UP[i % 4]);
    check("x1_pos", pos0, 2);
    check("x1_cnt", n_cnt0 - base0, 2);
    mode = 2'd1;
    base0 = n_cnt0;
    for (int i = 0; i < 4; i++) phase(DN[i]);
    check("x2_pos", pos0, 0);
    check("x2_cnt", n_cnt0 - base0, 2);

    // 3-cycle glitch is shorter than the 4-cycle filter
    mode = 2'd2;
    base0 = n_cnt0;
    ebase = n_err0;
    @(negedge clk) ina = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) ina = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("glitch_cnt", n_cnt0 - base0, 0);
    check("glitch_err", n_err0 - ebase, 0);

    phase(2'b11);
    check("illegal_err", n_err0 - ebase, 1);
    check("illegal_cnt", n_cnt0 - base0, 0);
    check("illegal_pos", pos0, 0);
    phase(2'b00);
    check("illegal_back_err", n_err0 - ebase, 2);
    check("illegal_back_pos", pos0, 0);

    base0 = n_cnt0;
    base1 = n_cnt1;
    for (int i = 0; i < 8; i++) phase(UP[i % 4]);
    check("sat_pos_8", pos0, 7);
    check("wrap_pos_8", pos1, 4'h8);
    phase(UP[0]);
    phase(UP[1]);
    check("sat_pos_10", pos0, 7);
    check("wrap_pos_10", pos1, 4'hA);
    check("sat_cnt_10", n_cnt0 - base0, 10);
    check("wrap_cnt_10", n_cnt1 - base1, 10);

    // pos_clr lands on the same edge as the 11 -> 01 up step
    @(negedge clk) ina = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk) pos_clr = 1'b1;
    @(posedge clk);
    #1;
    check("clr_step_cnt", cnt0, 1);
    check("clr_step_dir", dir0, 1);
    check("clr_step_pos_sat", pos0, 0);
    check("clr_step_pos_wrap", pos1, 0);
    @(negedge clk) pos_clr = 1'b0;

    @(negedge clk) sw = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk) sw = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("bounce_press", n_press, 0);
    check("bounce_sw_out", sw_out0, 0);

    for (int k = 1; k <= 2; k++) begin
      @(negedge clk) sw = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("hold_sw_out", sw_out0, 1);
      check("hold_press", n_press, k);
      check("hold_long", n_long, k);
      check("long_delay", t_long - t_rise, 50);
      @(negedge clk) sw = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      check("release_sw_out", sw_out0, 0);
    end
    check("release_no_long", n_long, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
